apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Parametrised APB master bridge.
- Accepts single transfer requests on a valid/ready request channel and runs them as APB SETUP/ACCESS sequences to one of SLAVES_NUM slaves, selected by the upper address bits.
- Returns a single-cycle response with read data and a 2-bit response code (OKAY, SLVERR, DECERR, TIMEOUT).
- Sits between the CPU-side interconnect and the peripheral slaves (UART, GPIO, timers).

Parameters:
- DATA_WIDTH, 32, PWDATA/PRDATA width; multiple of 8.
- ADDR_WIDTH, 8, PADDR width.
- SLAVES_NUM, 4, number of APB slaves; must be >= 2.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for PREADY; 0 disables the timeout.
- Derived localparams: STRB_WIDTH = DATA_WIDTH/8; SEL_BITS = clog2(SLAVES_NUM).

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  write data
- req_strb  in  STRB_WIDTH  write byte strobes
- rsp_valid  out  1  response pulse
- rsp_rdata  out  DATA_WIDTH  read data
- rsp_resp  out  2  00 OKAY, 01 SLVERR, 10 DECERR, 11 TIMEOUT
- PADDR  out  ADDR_WIDTH  APB address
- PSEL  out  SLAVES_NUM  one-hot slave select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PSTRB  out  STRB_WIDTH  APB strobes
- PRDATA  in  SLAVES_NUM*DATA_WIDTH  flattened read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- PREADY  in  SLAVES_NUM  per-slave ready
- PSLVERR  in  SLAVES_NUM  per-slave error

Interface note:
- One clock; reset is asynchronous and active-high.
- Clock is PCLK; reset is PRESET.

Behaviour:
- Reset: PRESET high immediately forces state IDLE and drives all outputs to their reset values:
  - req_ready=1
  - rsp_valid=0, rsp_rdata=0, rsp_resp=0
  - PADDR=0, PSEL=0, PENABLE=0, PWRITE=0, PWDATA=0, PSTRB=0
  - timeout counter=0
- Reset mid-transfer: the transfer is abandoned and no response is issued.
- Registered outputs: all APB and response outputs come from registers. There is no combinational path from req_* or PREADY/PRDATA to outputs.
- req_ready = 1 only in state IDLE (decoded from the state register).
- Decode: idx = req_addr[ADDR_WIDTH-1 -: SEL_BITS].
  - idx >= SLAVES_NUM is a decode error.
  - idx, addr, write, wdata and strb are captured at acceptance (req_valid && req_ready at a PCLK edge).
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE -> SETUP on accept with a valid idx.
  - IDLE -> RESP on accept with an invalid idx: rsp_resp=10, rsp_rdata=0, PSEL never asserted.
  - SETUP: PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PWDATA valid. For a write PSTRB=captured strb; for a read PSTRB=0. SETUP -> ACCESS unconditionally.
  - ACCESS: PENABLE=1, PSEL held, all APB outputs stable. Only PREADY[idx]/PSLVERR[idx]/PRDATA slice idx are observed; other slaves are ignored.
  - ACCESS with PREADY[idx]=1 -> RESP:
    - rsp_resp = PSLVERR[idx] ? 01 : 00
    - rsp_rdata = PRDATA slice idx for reads, 0 for writes
    - PSEL and PENABLE drop to 0 at the same edge.
  - ACCESS with PREADY[idx]=0: the counter increments. When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, go to RESP with rsp_resp=11, rsp_rdata=0, and drop PSEL/PENABLE. The counter clears on leaving ACCESS.
  - RESP: rsp_valid=1 for exactly one cycle; RESP -> IDLE. rsp_rdata/rsp_resp hold until the next response.
- Latency (zero-wait-state slave): accept at edge E0 -> SETUP in cycle 1, ACCESS in cycle 2, RESP in cycle 3.
  - rsp_valid is high in the cycle after E2.
  - Minimum issue interval is 4 cycles per transfer.
- PSLVERR is sampled only when PREADY[idx]=1 in ACCESS.
- PWDATA/PADDR keep their last values in IDLE; only PSEL/PENABLE return to 0.
- req_valid arriving in IDLE in the same cycle rsp_valid falls is accepted normally. No request is lost, and a request is never accepted outside IDLE.

Test Plan:
- Write to addr 0x44 (SLAVES_NUM=4, idx 1), data 0xDEADBEEF, strb 0xF, PREADY[1]=1: PSEL=0010 in cycle 1, PENABLE=1 in cycle 2, PWDATA=0xDEADBEEF, PSTRB=0xF; rsp_valid in cycle 3 with rsp_resp=00.
- Read addr 0xC0 (idx 3), slave 3 holds PREADY low for 3 cycles, PRDATA slice 3=0x12345678: ACCESS lasts 4 cycles, PSTRB=0; rsp_rdata=0x12345678, rsp_resp=00.
- Slave 2 returns PREADY=1 with PSLVERR=1 on a write: rsp_resp=01, rsp_rdata=0; a PSLVERR pulse while PREADY=0 is ignored.
- SLAVES_NUM=3, read addr 0xC0 (idx 3): PSEL stays 000 throughout; rsp_valid one cycle after accept with rsp_resp=10.
- TIMEOUT_CYCLES=16, PREADY held at 0: PENABLE high for exactly 16 cycles; then PSEL/PENABLE=0, rsp_resp=11, req_ready=1 one cycle later.
- Assert PRESET during ACCESS: PSEL/PENABLE go to 0 immediately; no rsp_valid; after release, a back-to-back pair of reads completes in 8 cycles with correct data.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// ----------------------------------------------------------------------------
// apb_master_bridge_if
// Groups the request/response channel and the APB bus of apb_master_bridge.
//   request  : req_valid, req_ready, req_write, req_addr, req_wdata, req_strb
//   response : rsp_valid, rsp_rdata, rsp_resp
//   APB      : PADDR, PSEL (one-hot), PENABLE, PWRITE, PWDATA, PSTRB,
//              PRDATA (flattened, slave i at [i*DATA_WIDTH +: DATA_WIDTH]),
//              PREADY, PSLVERR (per slave)
// modport master : the bridge side (drives APB and the response channel)
// modport slave  : the environment side (requester plus APB slaves)
// ----------------------------------------------------------------------------
interface apb_master_bridge_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int SLAVES_NUM = 4
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                             req_valid;
   logic                             req_ready;
   logic                             req_write;
   logic [ADDR_WIDTH-1:0]            req_addr;
   logic [DATA_WIDTH-1:0]            req_wdata;
   logic [STRB_WIDTH-1:0]            req_strb;
   logic                             rsp_valid;
   logic [DATA_WIDTH-1:0]            rsp_rdata;
   logic [1:0]                       rsp_resp;
   logic [ADDR_WIDTH-1:0]            PADDR;
   logic [SLAVES_NUM-1:0]            PSEL;
   logic                             PENABLE;
   logic                             PWRITE;
   logic [DATA_WIDTH-1:0]            PWDATA;
   logic [STRB_WIDTH-1:0]            PSTRB;
   logic [SLAVES_NUM*DATA_WIDTH-1:0] PRDATA;
   logic [SLAVES_NUM-1:0]            PREADY;
   logic [SLAVES_NUM-1:0]            PSLVERR;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_strb,
      output req_ready, rsp_valid, rsp_rdata, rsp_resp,
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_strb,
      input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_master_bridge.sv
// ----------------------------------------------------------------------------
// apb_master_bridge
// Runs single requests from a valid/ready channel as APB SETUP/ACCESS
// transfers to one of SLAVES_NUM slaves (selected by the top address bits)
// and returns a one-cycle response with read data and a response code
// (00 OKAY, 01 SLVERR, 10 DECERR, 11 TIMEOUT).
// Ports:
//   PCLK    - clock
//   PRESET  - asynchronous active-high reset
//   bus     - apb_master_bridge_if.master (request, response and APB signals)
// ----------------------------------------------------------------------------
module apb_master_bridge #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 8,
   parameter int SLAVES_NUM     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   apb_master_bridge_if.master     bus
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int SEL_BITS   = $clog2(SLAVES_NUM);
   localparam int CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [1:0] RESP_SLVERR  = 2'b01;
   localparam logic [1:0] RESP_DECERR  = 2'b10;
   localparam logic [1:0] RESP_TIMEOUT = 2'b11;

   logic [1:0]            state_q,     state_d;
   logic [SEL_BITS-1:0]   idx_q,       idx_d;
   logic [CNT_W-1:0]      cnt_q,       cnt_d;
   logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
   logic [SLAVES_NUM-1:0] psel_q,      psel_d;
   logic                  penable_q,   penable_d;
   logic                  pwrite_q,    pwrite_d;
   logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
   logic [STRB_WIDTH-1:0] pstrb_q,     pstrb_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]            rsp_resp_q,  rsp_resp_d;

   logic [SEL_BITS-1:0]   req_idx_s;
   logic                  idx_valid_s;
   logic                  pready_s;
   logic                  pslverr_s;
   logic [DATA_WIDTH-1:0] prdata_s;
   logic [CNT_W-1:0]      cnt_inc_s;
   logic                  timeout_hit_s;

   // Slave index comes from the top address bits; codes beyond the slave
   // count (possible when SLAVES_NUM is not a power of two) are decode errors.
   assign req_idx_s   = bus.req_addr[ADDR_WIDTH-1 -: SEL_BITS];
   assign idx_valid_s = ({1'b0, req_idx_s} < (SEL_BITS + 1)'(SLAVES_NUM));

   // Only the slave captured at acceptance is observed during ACCESS.
   assign pready_s  = bus.PREADY[idx_q];
   assign pslverr_s = bus.PSLVERR[idx_q];
   assign prdata_s  = bus.PRDATA[idx_q*DATA_WIDTH +: DATA_WIDTH];

   // The counter holds the number of completed wait cycles; a timeout fires
   // on the edge that would make it equal TIMEOUT_CYCLES, so PENABLE is high
   // for exactly TIMEOUT_CYCLES cycles.
   assign cnt_inc_s     = cnt_q + 1'b1;
   assign timeout_hit_s = (TIMEOUT_CYCLES != 0) && (cnt_inc_s == CNT_W'(TIMEOUT_CYCLES));

   // Next-state and next-output computation for the transfer FSM.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      paddr_d     = paddr_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               idx_d    = req_idx_s;
               paddr_d  = bus.req_addr;
               pwrite_d = bus.req_write;
               pwdata_d = bus.req_wdata;
               pstrb_d  = bus.req_write ? bus.req_strb : '0;
               if (idx_valid_s) begin
                  state_d = ST_SETUP;
                  psel_d  = {{(SLAVES_NUM-1){1'b0}}, 1'b1} << req_idx_s;
               end else begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_resp_d  = RESP_DECERR;
                  rsp_rdata_d = '0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_d   = ST_ACCESS;
            penable_d = 1'b1;
         end
         ST_ACCESS: begin
            if (pready_s) begin
               state_d     = ST_RESP;
               psel_d      = '0;
               penable_d   = 1'b0;
               cnt_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_resp_d  = pslverr_s ? RESP_SLVERR : RESP_OKAY;
               rsp_rdata_d = pwrite_q ? '0 : prdata_s;
            end else if (timeout_hit_s) begin
               state_d     = ST_RESP;
               psel_d      = '0;
               penable_d   = 1'b0;
               cnt_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_resp_d  = RESP_TIMEOUT;
               rsp_rdata_d = '0;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            psel_d    = '0;
            penable_d = 1'b0;
            cnt_d     = '0;
         end
      endcase
   end

   // State and output registers; reset abandons any transfer in flight.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         paddr_q     <= '0;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         paddr_q     <= paddr_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_resp  = rsp_resp_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PSEL      = psel_q;
   assign bus.PENABLE   = penable_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PWDATA    = pwdata_q;
   assign bus.PSTRB     = pstrb_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// ----------------------------------------------------------------------------
// tb_apb_master_bridge
// Self-checking bench: a table of directed transfers, randomized transfers
// checked against a reference model of the response rules, and hand-written
// sequences for reset during ACCESS, back-to-back issue and decode errors on
// a three-slave instance.
// ----------------------------------------------------------------------------
module tb_apb_master_bridge;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int N  = 4;
   localparam int SW = DW / 8;
   localparam int TO = 16;

   typedef struct {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] strb;
      int            wait_n;
      logic          err;
      logic [DW-1:0] rdata;
      logic [1:0]    exp_resp;
      logic [DW-1:0] exp_rdata;
      int            exp_access;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   cyc       = 0;

   always #5 clk = ~clk;

   // free-running cycle counter used for interval measurements
   always @(posedge clk) cyc <= cyc + 1;

   apb_master_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLAVES_NUM(N)) bus ();
   apb_master_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLAVES_NUM(N), .TIMEOUT_CYCLES(TO))
      dut (.PCLK(clk), .PRESET(rst), .bus(bus));

   apb_master_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLAVES_NUM(3)) bus3 ();
   apb_master_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLAVES_NUM(3), .TIMEOUT_CYCLES(TO))
      dut3 (.PCLK(clk), .PRESET(rst), .bus(bus3));

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Reference: a slave that keeps PREADY low for wait_n ACCESS cycles needs
   // wait_n+1 ACCESS cycles, unless that exceeds the timeout budget.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      if (TO != 0 && v.wait_n >= TO) begin
         r.exp_resp   = 2'b11;
         r.exp_rdata  = '0;
         r.exp_access = TO;
      end else begin
         r.exp_resp   = v.err ? 2'b01 : 2'b00;
         r.exp_rdata  = v.write ? '0 : v.rdata;
         r.exp_access = v.wait_n + 1;
      end
      return r;
   endfunction

   // One transfer on the 4-slave DUT. Starts and ends at a negedge in IDLE.
   task automatic run_xfer(input vec_t v, input string tag);
      int            idx;
      logic [N-1:0]  onehot;
      int            t, acc, psel_cyc, pen_cyc, rsp_cyc, unstable, ready_bad;
      logic [1:0]    resp;
      logic [DW-1:0] rdata;
      logic [AW-1:0] s_addr;
      logic [DW-1:0] s_wdata;
      logic [SW-1:0] s_strb;
      logic          s_write;
      idx = int'(v.addr >> (AW - 2));
      onehot = 4'b0001 << idx;
      t = 0; acc = 0; psel_cyc = 0; pen_cyc = 0; rsp_cyc = 0; unstable = 0; ready_bad = 0;
      resp = 2'b00; rdata = '0;
      s_addr = '0; s_wdata = '0; s_strb = '0; s_write = 1'b0;
      check($sformatf("%s_ready_idle", tag), 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1;
      bus.req_write = v.write;
      bus.req_addr  = v.addr;
      bus.req_wdata = v.wdata;
      bus.req_strb  = v.strb;
      bus.PRDATA    = {$urandom, $urandom, $urandom, $urandom};
      bus.PRDATA[idx*DW +: DW] = v.rdata;
      bus.PREADY    = '0;
      bus.PSLVERR   = N'($urandom);
      while (rsp_cyc == 0 && t < 40) begin
         @(posedge clk);
         @(negedge clk);
         t++;
         bus.req_valid = 1'b0;
         if (bus.PSEL != '0) psel_cyc++;
         if (bus.PENABLE) pen_cyc++;
         if (bus.req_ready) ready_bad++;
         if (t == 1) begin
            check($sformatf("%s_setup_psel", tag), 64'(bus.PSEL), 64'(onehot));
            check($sformatf("%s_setup_penable", tag), 64'(bus.PENABLE), 64'd0);
            check($sformatf("%s_setup_paddr", tag), 64'(bus.PADDR), 64'(v.addr));
            check($sformatf("%s_setup_pwrite", tag), 64'(bus.PWRITE), 64'(v.write));
            check($sformatf("%s_setup_pstrb", tag), 64'(bus.PSTRB), v.write ? 64'(v.strb) : 64'd0);
            if (v.write) check($sformatf("%s_setup_pwdata", tag), 64'(bus.PWDATA), 64'(v.wdata));
            s_addr = bus.PADDR; s_wdata = bus.PWDATA; s_strb = bus.PSTRB; s_write = bus.PWRITE;
         end else if (bus.PENABLE) begin
            if (bus.PADDR !== s_addr || bus.PWDATA !== s_wdata || bus.PSTRB !== s_strb ||
                bus.PWRITE !== s_write || bus.PSEL !== onehot) unstable++;
         end
         if (bus.rsp_valid) begin
            rsp_cyc = t;
            resp    = bus.rsp_resp;
            rdata   = bus.rsp_rdata;
         end
         // slave behaviour for the coming edge; other slaves toggle randomly
         if (bus.PSEL[idx] && bus.PENABLE) acc++;
         bus.PREADY  = N'($urandom);
         bus.PSLVERR = N'($urandom);
         bus.PREADY[idx]  = bus.PSEL[idx] && bus.PENABLE && (acc > v.wait_n);
         bus.PSLVERR[idx] = bus.PREADY[idx] ? v.err : 1'b1;
      end
      check($sformatf("%s_rsp_cycle", tag), 64'(rsp_cyc), 64'(v.exp_access + 2));
      check($sformatf("%s_resp", tag), 64'(resp), 64'(v.exp_resp));
      check($sformatf("%s_rdata", tag), 64'(rdata), 64'(v.exp_rdata));
      check($sformatf("%s_penable_cycles", tag), 64'(pen_cyc), 64'(v.exp_access));
      check($sformatf("%s_psel_cycles", tag), 64'(psel_cyc), 64'(v.exp_access + 1));
      check($sformatf("%s_apb_stable", tag), 64'(unstable), 64'd0);
      check($sformatf("%s_ready_busy", tag), 64'(ready_bad), 64'd0);
      bus.PREADY = '0;
      bus.PSLVERR = '0;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s_rsp_pulse", tag), 64'(bus.rsp_valid), 64'd0);
      check($sformatf("%s_ready_after", tag), 64'(bus.req_ready), 64'd1);
      check($sformatf("%s_resp_hold", tag), 64'(bus.rsp_resp), 64'(v.exp_resp));
      check($sformatf("%s_rdata_hold", tag), 64'(bus.rsp_rdata), 64'(v.exp_rdata));
      check($sformatf("%s_idle_psel", tag), 64'({bus.PSEL, bus.PENABLE}), 64'd0);
   endtask

   vec_t vecs[7];
   vec_t rv;
   int   c0, rsp_seen, psel_or;

   initial begin
      // directed table: {write, addr, wdata, strb, wait, err, prdata, resp, rdata, access}
      vecs[0] = '{1'b1, 8'h44, 32'hDEADBEEF, 4'hF, 0,  1'b0, 32'h0BAD0BAD, 2'b00, 32'h0,        1};
      vecs[1] = '{1'b0, 8'hC0, 32'h0,        4'hA, 3,  1'b0, 32'h12345678, 2'b00, 32'h12345678, 4};
      vecs[2] = '{1'b1, 8'h80, 32'h55AA55AA, 4'h3, 2,  1'b1, 32'h77777777, 2'b01, 32'h0,        3};
      vecs[3] = '{1'b0, 8'h10, 32'h0,        4'h0, 0,  1'b1, 32'hA5A5A5A5, 2'b01, 32'hA5A5A5A5, 1};
      vecs[4] = '{1'b0, 8'h7C, 32'h0,        4'h0, 15, 1'b0, 32'h0F0F1234, 2'b00, 32'h0F0F1234, 16};
      vecs[5] = '{1'b0, 8'h40, 32'h0,        4'h0, 16, 1'b0, 32'h11111111, 2'b11, 32'h0,        16};
      vecs[6] = '{1'b1, 8'hFF, 32'hCAFEBABE, 4'h9, 20, 1'b0, 32'h22222222, 2'b11, 32'h0,        16};

      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.req_strb = '0; bus.PRDATA = '0; bus.PREADY = '0; bus.PSLVERR = '0;
      bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0;
      bus3.req_strb = '0; bus3.PRDATA = '0; bus3.PREADY = '0; bus3.PSLVERR = '0;
      repeat (2) @(negedge clk);
      check("reset_req_ready", 64'(bus.req_ready), 64'd1);
      check("reset_rsp", 64'({bus.rsp_valid, bus.rsp_resp, bus.rsp_rdata}), 64'd0);
      check("reset_apb_ctl", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB}), 64'd0);
      check("reset_paddr", 64'(bus.PADDR), 64'd0);
      check("reset_pwdata", 64'(bus.PWDATA), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 30; i++) begin
         rv.write  = 1'(($urandom) & 1);
         rv.addr   = AW'($urandom);
         rv.wdata  = $urandom;
         rv.strb   = SW'($urandom);
         rv.wait_n = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(14, 18));
         rv.err    = 1'($urandom & 1);
         rv.rdata  = $urandom;
         rv = model(rv);
         run_xfer(rv, $sformatf("rnd%0d", i));
      end

      // reset while a read is waiting in ACCESS
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'h84;
      bus.PREADY = '0; bus.PSLVERR = '0;
      @(posedge clk); @(negedge clk);
      bus.req_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      check("rst_in_access", 64'({bus.PSEL, bus.PENABLE}), 64'({4'b0100, 1'b1}));
      rst = 1'b1;
      #1;
      check("rst_psel_penable", 64'({bus.PSEL, bus.PENABLE}), 64'd0);
      check("rst_req_ready", 64'(bus.req_ready), 64'd1);
      rsp_seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 1) rst = 1'b0;
         if (bus.rsp_valid) rsp_seen++;
      end
      check("rst_no_rsp", 64'(rsp_seen), 64'd0);
      c0 = cyc;
      rv = '{1'b0, 8'h20, 32'h0, 4'h0, 0, 1'b0, 32'h13572468, 2'b00, 32'h13572468, 1};
      run_xfer(rv, "b2b_a");
      rv = '{1'b0, 8'hE4, 32'h0, 4'h0, 0, 1'b0, 32'h89ABCDEF, 2'b00, 32'h89ABCDEF, 1};
      run_xfer(rv, "b2b_b");
      check("b2b_cycles", 64'(cyc - c0), 64'd8);

      // three-slave instance: a valid read to slave 2, then a decode error
      bus3.PREADY = 3'b111;
      bus3.PRDATA = {32'hCAFEF00D, 32'h0, 32'h0};
      bus3.req_valid = 1'b1; bus3.req_write = 1'b0; bus3.req_addr = 8'h80;
      @(posedge clk); @(negedge clk);
      bus3.req_valid = 1'b0;
      check("s3_setup_psel", 64'(bus3.PSEL), 64'd4);
      repeat (2) @(negedge clk);
      check("s3_rd_rsp", 64'({bus3.rsp_valid, bus3.rsp_resp}), 64'({1'b1, 2'b00}));
      check("s3_rd_data", 64'(bus3.rsp_rdata), 64'h0CAFEF00D);
      @(negedge clk);
      check("s3_ready", 64'(bus3.req_ready), 64'd1);
      bus3.req_valid = 1'b1; bus3.req_addr = 8'hC0;
      psel_or = 0;
      @(posedge clk); @(negedge clk);
      bus3.req_valid = 1'b0;
      if (bus3.PSEL != '0) psel_or++;
      check("s3_dec_rsp", 64'({bus3.rsp_valid, bus3.rsp_resp}), 64'({1'b1, 2'b10}));
      check("s3_dec_rdata", 64'(bus3.rsp_rdata), 64'd0);
      check("s3_dec_busy", 64'(bus3.req_ready), 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus3.PSEL != '0) psel_or++;
         if (k == 0) begin
            check("s3_dec_pulse", 64'(bus3.rsp_valid), 64'd0);
            check("s3_dec_ready", 64'(bus3.req_ready), 64'd1);
         end
      end
      check("s3_dec_psel", 64'(psel_or), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks", pass_cnt, total_cnt);
      $fatal(1, "watchdog expired");
   end
endmodule
